// File: rtl/ras_pkg.sv
// ras_pkg: shared types and constants for the decode-stage RAS recovery logic.
//   ADDR_W      width of PCs and return addresses
//   RET_OFFSET  return address = call PC + RET_OFFSET (MIPS delay slot)
//   ras_rc_state_t  recovery FSM state
//   ras_pred_t      IF/ID snapshot of one fetch-stage RAS prediction
package ras_pkg;

  localparam int ADDR_W     = 32;
  localparam int RET_OFFSET = 8;

  typedef enum logic {
    RAS_RC_IDLE  = 1'b0,
    RAS_RC_PUSH2 = 1'b1
  } ras_rc_state_t;

  typedef struct packed {
    logic              valid;
    logic              pred_call;
    logic              pred_ret;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ret_addr;
  } ras_pred_t;

endpackage

// File: rtl/ras_ifid_reg.sv
// ras_ifid_reg: IF/ID capture register for the RAS prediction of one instruction.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   if_*            fetch-stage instruction and RAS prediction
//   id_stall        hold every field
//   id_flush        kill the slot (wins over stall and load)
//   fire            the slot produced its recovery action this cycle
//   squash_set      a redirect is issued; next load is wrong-path
//   ifid            registered prediction record
//   done            the slot already fired (blocks a second fire while stalled)
module ras_ifid_reg
  import ras_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_pred_call,
  input  logic              if_pred_ret,
  input  logic [ADDR_W-1:0] if_ret_addr,
  input  logic              id_stall,
  input  logic              id_flush,
  input  logic              fire,
  input  logic              squash_set,
  output ras_pred_t         ifid,
  output logic              done
);

  logic squash;

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid <= '0;
      done <= 1'b0;
    end else if (id_flush) begin
      ifid.valid <= 1'b0;
      done       <= 1'b0;
    end else if (!id_stall) begin
      ifid.valid     <= if_valid & ~squash;
      // A slot flagged as both call and ret is handled as a ret only.
      ifid.pred_call <= if_pred_call & ~if_pred_ret;
      ifid.pred_ret  <= if_pred_ret;
      ifid.pc        <= if_pc;
      ifid.ret_addr  <= if_ret_addr;
      done           <= 1'b0;
    end else begin
      done <= done | fire;
    end
  end

  // squash kills exactly one load: the fetch slot that was already in flight
  // when the redirect went out. It survives stalls until that load happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      squash <= 1'b0;
    end else if (squash_set) begin
      squash <= 1'b1;
    end else if (!id_flush && !id_stall) begin
      squash <= 1'b0;
    end
  end

endmodule

// File: rtl/core_ras_recover.sv
// core_ras_recover: decode-stage checker for the fetch-stage return address stack.
// Compares the RAS prediction latched in IF/ID with the decoded instruction and,
// on a mismatch, repairs the RAS and redirects fetch to the fall-through PC.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_pc/if_pred_* fetch slot and its RAS prediction
//   if_ret_addr              address the RAS popped at fetch
//   id_stall, id_flush       IF/ID hold and kill
//   id_is_call, id_is_ret    decode of the instruction in ID
//   recover_push(_addr)      1-cycle push request to the RAS
//   recover_pop              1-cycle pop request to the RAS
//   redirect, redirect_pc    1-cycle fetch redirect to the fall-through PC
//   mispred_cnt              saturating count of mispredicted instructions
// Flow semantics: an instruction is presented by if_valid and is accepted into
// ID on any cycle without id_stall; id_flush discards it. There is no
// back-pressure on the recovery/redirect outputs; each is a single-cycle pulse
// that the consumer must take in the cycle it is asserted.
module core_ras_recover #(
  parameter int ADDR_W     = ras_pkg::ADDR_W,
  parameter int RET_OFFSET = ras_pkg::RET_OFFSET,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_pred_call,
  input  logic              if_pred_ret,
  input  logic [ADDR_W-1:0] if_ret_addr,
  input  logic              id_stall,
  input  logic              id_flush,
  input  logic              id_is_call,
  input  logic              id_is_ret,
  output logic              recover_push,
  output logic [ADDR_W-1:0] recover_push_addr,
  output logic              recover_pop,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  mispred_cnt
);
  import ras_pkg::*;

  ras_pred_t     ifid;
  logic          done;
  logic          fire;
  ras_rc_state_t state_q, state_d;
  logic [ADDR_W-1:0] push2_addr_q, push2_addr_d;

  logic              push_d, pop_d, redirect_d;
  logic [ADDR_W-1:0] push_addr_d, redirect_pc_d;
  logic              eval;
  logic              case_a, case_b, case_c, case_d, case_e;
  logic [ADDR_W-1:0] fall_pc, link_addr;

  ras_ifid_reg u_ifid (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_pred_call (if_pred_call),
    .if_pred_ret  (if_pred_ret),
    .if_ret_addr  (if_ret_addr),
    .id_stall     (id_stall),
    .id_flush     (id_flush),
    .fire         (fire),
    .squash_set   (redirect_d),
    .ifid         (ifid),
    .done         (done)
  );

  assign fall_pc   = ifid.pc + ADDR_W'(4);
  assign link_addr = ifid.pc + ADDR_W'(RET_OFFSET);

  // Classification; pred_call and pred_ret are mutually exclusive in IF/ID.
  always_comb begin
    case_b = ifid.pred_ret & id_is_call;
    case_a = ifid.pred_ret & ~id_is_call & ~id_is_ret;
    case_d = ifid.pred_call & id_is_ret;
    case_c = ifid.pred_call & ~id_is_call & ~id_is_ret;
    case_e = ~ifid.pred_call & ~ifid.pred_ret & id_is_call;
  end

  assign eval = ifid.valid & ~done & (state_q == RAS_RC_IDLE) & ~id_flush;
  assign fire = eval & (case_a | case_b | case_c | case_d | case_e);

  always_comb begin
    state_d       = state_q;
    push2_addr_d  = push2_addr_q;
    push_d        = 1'b0;
    push_addr_d   = '0;
    pop_d         = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    if (state_q == RAS_RC_PUSH2) begin
      // Second half of a call that was predicted as a return. A flush seen
      // now drops it: the call itself was on a killed path.
      state_d = RAS_RC_IDLE;
      if (!id_flush) begin
        push_d      = 1'b1;
        push_addr_d = push2_addr_q;
      end
    end else if (eval) begin
      if (case_b) begin
        push_d       = 1'b1;
        push_addr_d  = ifid.ret_addr;
        // IF/ID may advance next cycle, so keep the link address here.
        push2_addr_d = link_addr;
        state_d      = RAS_RC_PUSH2;
      end else if (case_a) begin
        push_d        = 1'b1;
        push_addr_d   = ifid.ret_addr;
        redirect_d    = 1'b1;
        redirect_pc_d = fall_pc;
      end else if (case_d) begin
        pop_d = 1'b1;
      end else if (case_c) begin
        pop_d         = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = fall_pc;
      end else if (case_e) begin
        push_d      = 1'b1;
        push_addr_d = link_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RAS_RC_IDLE;
      push2_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      push2_addr_q <= push2_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      recover_push      <= 1'b0;
      recover_push_addr <= '0;
      recover_pop       <= 1'b0;
      redirect          <= 1'b0;
      redirect_pc       <= '0;
    end else begin
      recover_push      <= push_d;
      recover_push_addr <= push_addr_d;
      recover_pop       <= pop_d;
      redirect          <= redirect_d;
      redirect_pc       <= redirect_pc_d;
    end
  end

  // Counted on the first action of an instruction only, so the double push
  // of a call mispredicted as a return counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispred_cnt <= '0;
    end else if (fire && (mispred_cnt != {CNT_W{1'b1}})) begin
      mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_ras_recover.sv
// tb_core_ras_recover: directed vector table, hand sequences and a randomized
// run against a rule-level reference model for core_ras_recover.
module tb_core_ras_recover;

  localparam int AW = 32;
  localparam int CW = 4;
  localparam int OW = 2 * AW + 3 + CW;   // {push, paddr, pop, redir, rpc, cnt}
  localparam int ACTW = OW - CW;

  // ---------------- clock / reset signals ----------------
  logic clk = 1'b0;
  logic rst, if_valid, if_pred_call, if_pred_ret, id_stall, id_flush, id_is_call, id_is_ret;
  logic [AW-1:0] if_pc, if_ret_addr;
  logic recover_push, recover_pop, redirect;
  logic [AW-1:0] recover_push_addr, redirect_pc;
  logic [CW-1:0] mispred_cnt;

  always #5 clk = ~clk;

  core_ras_recover #(.ADDR_W(AW), .RET_OFFSET(8), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .if_pred_call      (if_pred_call),
    .if_pred_ret       (if_pred_ret),
    .if_ret_addr       (if_ret_addr),
    .id_stall          (id_stall),
    .id_flush          (id_flush),
    .id_is_call        (id_is_call),
    .id_is_ret         (id_is_ret),
    .recover_push      (recover_push),
    .recover_push_addr (recover_push_addr),
    .recover_pop       (recover_pop),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .mispred_cnt       (mispred_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  function automatic logic [OW-1:0] dut_out();
    return {recover_push, recover_push_addr, recover_pop, redirect, redirect_pc, mispred_cnt};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got push=%0b addr=%h pop=%0b redir=%0b pc=%h cnt=%0d, expected push=%0b addr=%h pop=%0b redir=%0b pc=%h cnt=%0d",
               name, act[OW-1], act[OW-2 -: AW], act[AW+CW+1], act[AW+CW], act[AW+CW-1 -: AW], act[CW-1:0],
               exp[OW-1], exp[OW-2 -: AW], exp[AW+CW+1], exp[AW+CW], exp[AW+CW-1 -: AW], exp[CW-1:0]);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst, iv;
    logic [AW-1:0] ipc;
    logic          pcl, prt;
    logic [AW-1:0] ra;
    logic          st, fl, ic, ir;
    logic          ep;
    logic [AW-1:0] epa;
    logic          eo, er;
    logic [AW-1:0] erpc;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [AW-1:0] ipc, logic pcl, logic prt,
                              logic [AW-1:0] ra, logic st, logic fl, logic ic, logic ir,
                              logic ep, logic [AW-1:0] epa, logic eo, logic er,
                              logic [AW-1:0] erpc, logic [CW-1:0] ec);
    vec_t v;
    v.rst = r; v.iv = iv; v.ipc = ipc; v.pcl = pcl; v.prt = prt; v.ra = ra;
    v.st = st; v.fl = fl; v.ic = ic; v.ir = ir;
    v.ep = ep; v.epa = epa; v.eo = eo; v.er = er; v.erpc = erpc; v.ec = ec;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    rst = v.rst; if_valid = v.iv; if_pc = v.ipc; if_pred_call = v.pcl; if_pred_ret = v.prt;
    if_ret_addr = v.ra; id_stall = v.st; id_flush = v.fl; id_is_call = v.ic; id_is_ret = v.ir;
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(name, dut_out(), {v.ep, v.epa, v.eo, v.er, v.erpc, v.ec});
  endtask

  // ---------------- reference model ----------------
  // Tracks the instruction sitting in ID and the list of recovery actions it
  // still owes, derived directly from the prediction-vs-decode rules.
  logic          m_valid, m_pcall, m_pret, m_done, m_squash;
  logic [AW-1:0] m_pc, m_ra;
  int            m_cnt;
  logic [ACTW-1:0] m_pend[$];
  logic [ACTW-1:0] m_acts[$];

  function automatic logic [ACTW-1:0] act(logic p, logic [AW-1:0] pa, logic o, logic r, logic [AW-1:0] rp);
    return {p, pa, o, r, rp};
  endfunction

  function automatic void rules(logic pcall, logic pret, logic ic, logic ir, logic [AW-1:0] pc, logic [AW-1:0] ra);
    m_acts.delete();
    if (pret) begin
      if (ic) begin
        m_acts.push_back(act(1'b1, ra, 1'b0, 1'b0, '0));          // restore popped entry
        m_acts.push_back(act(1'b1, pc + 32'd8, 1'b0, 1'b0, '0));  // then the call's link
      end else if (!ir) begin
        m_acts.push_back(act(1'b1, ra, 1'b0, 1'b1, pc + 32'd4));
      end
    end else if (pcall) begin
      if (ir)       m_acts.push_back(act(1'b0, '0, 1'b1, 1'b0, '0));
      else if (!ic) m_acts.push_back(act(1'b0, '0, 1'b1, 1'b1, pc + 32'd4));
    end else if (ic) begin
      m_acts.push_back(act(1'b1, pc + 32'd8, 1'b0, 1'b0, '0));
    end
  endfunction

  task automatic model_step();
    logic [ACTW-1:0] a;
    logic fired;
    a = '0;
    fired = 1'b0;
    if (rst) begin
      m_valid = 0; m_pcall = 0; m_pret = 0; m_done = 0; m_squash = 0;
      m_pc = '0; m_ra = '0; m_cnt = 0;
      m_pend.delete();
    end else begin
      if (m_pend.size() > 0) begin
        a = m_pend.pop_front();
        if (id_flush) a = '0;
      end else if (m_valid && !m_done && !id_flush) begin
        rules(m_pcall, m_pret, id_is_call, id_is_ret, m_pc, m_ra);
        if (m_acts.size() > 0) begin
          fired = 1'b1;
          a = m_acts.pop_front();
          m_pend = m_acts;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end
      if (id_flush) begin
        m_valid = 0; m_done = 0;
      end else if (!id_stall) begin
        m_valid = if_valid && !m_squash;
        m_pret  = if_pred_ret;
        m_pcall = if_pred_call && !if_pred_ret;
        m_pc    = if_pc;
        m_ra    = if_ret_addr;
        m_done  = 0;
        m_squash = 0;
      end else if (fired) begin
        m_done = 1;
      end
      if (a[AW]) m_squash = 1;   // redirect bit of the action
    end
    exp_q.push_back({a, CW'(m_cnt)});
  endtask

  // ---------------- test ----------------
  initial begin
    int exp_cnt;
    logic [AW-1:0] pc;
    vec_t v;
    logic [OW-1:0] e;

    rst = 1; if_valid = 0; if_pc = '0; if_pred_call = 0; if_pred_ret = 0; if_ret_addr = '0;
    id_stall = 0; id_flush = 0; id_is_call = 0; id_is_ret = 0;

    //            r iv ipc           pcl prt ra            st fl ic ir  ep epa           eo er erpc          ec
    vecs.push_back(mk(1,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        0)); // reset
    vecs.push_back(mk(0,1,32'h00400040, 0,1,32'h00400120, 0,0,0,0, 0,32'h0,        0,0,32'h0,        0)); // push-back
    vecs.push_back(mk(0,1,32'h00400044, 0,0,32'h0,        0,0,0,0, 1,32'h00400120, 0,1,32'h00400044, 1));
    vecs.push_back(mk(0,1,32'h00400048, 0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        1));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,1,0, 0,32'h0,        0,0,32'h0,        1)); // squashed slot
    vecs.push_back(mk(0,1,32'h00400080, 0,1,32'h00400200, 0,0,0,0, 0,32'h0,        0,0,32'h0,        1)); // double push
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,1,0, 1,32'h00400200, 0,0,32'h0,        2));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 1,32'h00400088, 0,0,32'h0,        2));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        2));
    vecs.push_back(mk(0,1,32'h00400100, 1,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        2)); // false call + stall
    vecs.push_back(mk(0,1,32'h00400104, 0,0,32'h0,        1,0,0,0, 0,32'h0,        1,1,32'h00400104, 3));
    vecs.push_back(mk(0,1,32'h00400104, 0,0,32'h0,        1,0,0,0, 0,32'h0,        0,0,32'h0,        3));
    vecs.push_back(mk(0,1,32'h00400104, 0,0,32'h0,        1,0,0,0, 0,32'h0,        0,0,32'h0,        3));
    vecs.push_back(mk(0,1,32'h00400104, 0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        3));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,1,0, 0,32'h0,        0,0,32'h0,        3));
    vecs.push_back(mk(0,1,32'h00400300, 0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        3)); // missed call
    vecs.push_back(mk(0,1,32'h00400400, 1,0,32'h0,        0,0,1,0, 1,32'h00400308, 0,0,32'h0,        4));
    vecs.push_back(mk(0,1,32'h00400500, 0,1,32'h00000123, 0,0,1,0, 0,32'h0,        0,0,32'h0,        4)); // correct call
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,1, 0,32'h0,        0,0,32'h0,        4)); // correct ret
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        4));
    vecs.push_back(mk(0,1,32'h00400600, 0,1,32'h00400700, 0,0,0,0, 0,32'h0,        0,0,32'h0,        4)); // flush in PUSH2
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,1,0, 1,32'h00400700, 0,0,32'h0,        5));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,1,0,0, 0,32'h0,        0,0,32'h0,        5));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        5));
    vecs.push_back(mk(0,1,32'h00400800, 1,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        5)); // flush kills ID
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,1,0,0, 0,32'h0,        0,0,32'h0,        5));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        5));
    vecs.push_back(mk(0,1,32'h00400900, 0,1,32'h00400A00, 0,0,0,0, 0,32'h0,        0,0,32'h0,        5)); // reset in PUSH2
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,1,0, 1,32'h00400A00, 0,0,32'h0,        6));
    vecs.push_back(mk(1,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        0));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        0));
    vecs.push_back(mk(0,1,32'h00400B00, 1,1,32'h00400C00, 0,0,0,0, 0,32'h0,        0,0,32'h0,        0)); // both preds = ret
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 1,32'h00400C00, 0,1,32'h00400B04, 1));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        1));
    vecs.push_back(mk(0,1,32'hFFFFFFFC, 1,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        1)); // PC wrap
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        1,1,32'h00000000, 2));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        2));
    vecs.push_back(mk(0,1,32'h00400D00, 1,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        2)); // call pred, JR
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,1, 0,32'h0,        1,0,32'h0,        3));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,0,0,0, 0,32'h0,        0,0,32'h0,        3));

    for (int i = 0; i < vecs.size(); i++) apply_vec($sformatf("vec[%0d]", i), vecs[i]);

    // Saturation: 17 false-call events on top of the current count of 3.
    exp_cnt = 3;
    for (int k = 0; k < 17; k++) begin
      pc = 32'h00401000 + 32'(k * 16);
      apply_vec($sformatf("sat_load[%0d]", k),
                mk(0,1,pc,1,0,32'h0, 0,0,0,0, 0,32'h0,0,0,32'h0, CW'(exp_cnt)));
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      apply_vec($sformatf("sat_fire[%0d]", k),
                mk(0,0,32'h0,0,0,32'h0, 0,0,0,0, 0,32'h0,1,1,pc + 32'd4, CW'(exp_cnt)));
      apply_vec($sformatf("sat_idle[%0d]", k),
                mk(0,0,32'h0,0,0,32'h0, 0,0,0,0, 0,32'h0,0,0,32'h0, CW'(exp_cnt)));
    end

    // Randomized run against the reference model.
    v = mk(1,0,32'h0,0,0,32'h0,0,0,0,0,0,32'h0,0,0,32'h0,0);
    drive(v);
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rand_reset", dut_out(), e);
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) if_pc = 32'hFFFF_FFF0 | (if_pc & 32'h0000_000C);
      case ($urandom_range(0, 3))
        0: begin if_pred_call = 0; if_pred_ret = 0; end
        1: begin if_pred_call = 1; if_pred_ret = 0; end
        2: begin if_pred_call = 0; if_pred_ret = 1; end
        default: begin if_pred_call = 1; if_pred_ret = 1; end
      endcase
      if_ret_addr = $urandom();
      id_stall = ($urandom_range(0, 3) == 0);
      id_flush = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0, 1: begin id_is_call = 0; id_is_ret = 0; end
        2, 3: begin id_is_call = 1; id_is_ret = 0; end
        4:    begin id_is_call = 0; id_is_ret = 1; end
        default: begin id_is_call = 1; id_is_ret = 1; end
      endcase
      model_step();
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("rand[%0d]", n), dut_out(), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
